// File: rtl/icu_lfb_fill.sv
// I-cache line-fill buffer: miss launch, critical-word forward,
// hit-under-fill and full-line write-back to the cache array.
module icu_lfb_fill #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BEATS  = 4,
  parameter int WRAP   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ifu_icu_req_ic1,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0] ifu_icu_addr_ic1,
  output logic                      icu_ifu_ack_ic1,
  output logic                      icu_ifu_data_valid_ic2,
  output logic [DATA_W-1:0]         icu_ifu_data_ic2,
  output logic                      icu_biu_req,
  output logic [ADDR_W-1:0]         icu_biu_addr,
  input  logic                      biu_icu_ack,
  input  logic                      biu_icu_data_valid,
  input  logic [DATA_W-1:0]         biu_icu_data,
  input  logic                      biu_icu_data_last,
  output logic                      lfb_wr_valid,
  output logic [ADDR_W-1:0]         lfb_wr_addr,
  output logic [BEATS*DATA_W-1:0]   lfb_wr_data,
  output logic                      lfb_err
);

  localparam int OFF   = $clog2(DATA_W/8);
  localparam int BW    = $clog2(BEATS);
  localparam int TAG_W = ADDR_W - OFF - BW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [TAG_W-1:0]  r_tag;
  logic [BW-1:0]     r_crit;
  logic [BW-1:0]     r_pidx;
  logic              r_line_valid;
  logic              r_pending;
  logic [BEATS-1:0]  r_present;
  logic [DATA_W-1:0] r_data [BEATS];
  logic [BW:0]       r_cnt;
  logic              r_err;
  logic              r_ic2_valid;
  logic [DATA_W-1:0] r_ic2_data;

  logic [TAG_W-1:0]  w_tag;
  logic [BW-1:0]     w_idx;
  logic [BW-1:0]     w_start;
  logic [BW-1:0]     w_aidx;
  logic              w_hit;
  logic              w_ack;
  logic              w_miss;
  logic              w_beat;
  logic              w_klast;
  logic              w_fill_end;
  logic              w_arr_hit;
  logic              w_have;
  logic [DATA_W-1:0] w_have_data;
  logic              w_biu_req;
  logic              w_wr_valid;

  assign w_tag   = ifu_icu_addr_ic1[ADDR_W-OFF-1:BW];
  assign w_idx   = ifu_icu_addr_ic1[BW-1:0];
  assign w_start = (WRAP != 0) ? r_crit : '0;
  assign w_aidx  = w_start + r_cnt[BW-1:0];

  assign w_hit = (r_tag == w_tag) &
                 (r_line_valid | (r_state == S_REQ) |
                  (r_state == S_FILL));

  assign w_ack = ifu_icu_req_ic1 & ~reset & ~r_pending &
                 (w_hit | (r_state == S_IDLE));

  // An ack without a hit can only happen in IDLE.
  assign w_miss = w_ack & ~w_hit;

  assign w_beat     = (r_state == S_FILL) & biu_icu_data_valid;
  assign w_klast    = (r_cnt == (BW+1)'(BEATS-1));
  assign w_fill_end = w_beat & w_klast;

  // A beat landing in the same cycle as the hit request is forwarded.
  assign w_arr_hit   = w_beat & (w_aidx == w_idx);
  assign w_have      = r_present[w_idx] | w_arr_hit;
  assign w_have_data = r_present[w_idx] ? r_data[w_idx]
                                        : biu_icu_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_biu_req  = 1'b0;
    w_wr_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_miss) w_nxt = S_REQ;
      end
      S_REQ: begin
        w_biu_req = 1'b1;
        if (biu_icu_ack) w_nxt = S_FILL;
      end
      S_FILL: begin
        if (w_fill_end) w_nxt = S_DONE;
      end
      S_DONE: begin
        w_wr_valid = 1'b1;
        w_nxt      = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag        <= '0;
      r_crit       <= '0;
      r_pidx       <= '0;
      r_line_valid <= 1'b0;
      r_pending    <= 1'b0;
      r_present    <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_ic2_valid  <= 1'b0;
      r_ic2_data   <= '0;
      for (int i = 0; i < BEATS; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_ic2_valid <= 1'b0;

      if (w_beat) begin
        r_data[w_aidx]    <= biu_icu_data;
        r_present[w_aidx] <= 1'b1;
        r_cnt             <= r_cnt + 1'b1;
      end

      if (w_beat & (biu_icu_data_last != w_klast)) begin
        r_err <= 1'b1;
      end
      if (biu_icu_data_valid & (r_state != S_FILL)) begin
        r_err <= 1'b1;
      end

      if (r_state == S_DONE) begin
        r_line_valid <= 1'b1;
        r_cnt        <= '0;
      end

      if (r_pending & w_beat & (w_aidx == r_pidx)) begin
        r_pending   <= 1'b0;
        r_ic2_valid <= 1'b1;
        r_ic2_data  <= biu_icu_data;
      end

      if (w_ack) begin
        if (w_hit) begin
          if (w_have) begin
            r_ic2_valid <= 1'b1;
            r_ic2_data  <= w_have_data;
          end else begin
            r_pending <= 1'b1;
            r_pidx    <= w_idx;
          end
        end else begin
          r_tag        <= w_tag;
          r_crit       <= w_idx;
          r_present    <= '0;
          r_line_valid <= 1'b0;
          r_pending    <= 1'b1;
          r_pidx       <= w_idx;
          r_cnt        <= '0;
        end
      end
    end
  end

  assign icu_ifu_ack_ic1        = w_ack;
  assign icu_ifu_data_valid_ic2 = r_ic2_valid;
  assign icu_ifu_data_ic2       = r_ic2_data;
  assign icu_biu_req            = w_biu_req;
  assign icu_biu_addr           = {r_tag, w_start, {OFF{1'b0}}};
  assign lfb_wr_valid           = w_wr_valid;
  assign lfb_wr_addr            = {r_tag, {(OFF+BW){1'b0}}};
  assign lfb_err                = r_err;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_wr
    assign lfb_wr_data[gi*DATA_W +: DATA_W] = r_data[gi];
  end

endmodule

// File: doc/icu_lfb_fill.md
# icu_lfb_fill

Parametrised instruction-cache miss / line-fill-buffer (LFB) engine between the IFU fetch pipe (ic1/ic2) and the BIU. It accepts one fetch request per ic1 cycle and launches a line fill on an LFB miss. It forwards the requested beat to ic2 as soon as that beat arrives (critical word), serves later same-line fetches from the LFB (hit-under-fill), and emits one full-line write to the cache array when the fill completes. It generalises the fixed 4×64-bit fill path: line length, beat width and wrap-first ordering are parameters, and it adds hit-under-fill and protocol-error detection.

## Interface
- ADDR_W, 32, byte-address width.
- DATA_W, 64, beat width in bits; power of 2, ≥32. OFF = log2(DATA_W/8).
- BEATS, 4, beats per line; power of 2, ≥2. BW = log2(BEATS).
- WRAP, 0, 0 = BIU returns beat 0 first; 1 = BIU returns the critical beat first, wrapping modulo BEATS.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ifu_icu_req_ic1  in  1  fetch request.
- ifu_icu_addr_ic1  in  ADDR_W-OFF  beat address [ADDR_W-1:OFF].
- icu_ifu_ack_ic1  out  1  request accepted this cycle (combinational).
- icu_ifu_data_valid_ic2  out  1  fetch data valid (registered).
- icu_ifu_data_ic2  out  DATA_W  fetch data (registered).
- icu_biu_req  out  1  fill request; held until acked.
- icu_biu_addr  out  ADDR_W  fill byte address.
- biu_icu_ack  in  1  fill request accepted.
- biu_icu_data_valid  in  1  beat valid.
- biu_icu_data  in  DATA_W  beat data.
- biu_icu_data_last  in  1  final beat marker.
- lfb_wr_valid  out  1  one-cycle line write pulse.
- lfb_wr_addr  out  ADDR_W  line-aligned byte address.
- lfb_wr_data  out  BEATS*DATA_W  line; beat i at [i*DATA_W +: DATA_W].
- lfb_err  out  1  sticky BIU protocol error.

## Operation
- State: line tag (ADDR_W-OFF-BW bits), line_valid, per-beat present[BEATS], data[BEATS], beat counter cnt (BW+1 bits), pending flag plus pending beat index.
- FSM states:
  - IDLE: line_valid may be 1.
  - REQ: icu_biu_req=1; go to FILL on biu_icu_ack.
  - FILL: capture beats; after the BEATS-th beat go to DONE.
  - DONE: lfb_wr_valid=1 for one cycle; line_valid←1; go to IDLE.
- Hit = line tag matches addr[ADDR_W-1:OFF+BW] and (line_valid or state∈{REQ,FILL}).
- Ack rule: ack = req & ~reset & ~pending & (hit | state==IDLE).
  - A miss in REQ/FILL/DONE is not acked; the IFU holds the request and retries.
- Accepted hit with beat present: ic2 returns that beat next cycle.
- Accepted hit with beat absent: pending←1; ic2 returns the beat the cycle after it arrives.
- Accepted miss in IDLE:
  - tag←addr; present←0; line_valid←0; pending←1; go to REQ.
  - icu_biu_addr = line-aligned byte address when WRAP=0; byte address of the requested beat when WRAP=1. Held stable in REQ.
- Beat index of the k-th beat (k=0..BEATS-1) = (start + k) mod BEATS, where start = 0 (WRAP=0) or the critical index (WRAP=1). Each beat writes data and sets present.
- Protocol errors (lfb_err←1, sticky until reset):
  - biu_icu_data_last on any beat other than k=BEATS-1.
  - last absent on beat k=BEATS-1.
  - biu_icu_data_valid outside FILL.
  - The fill still completes on beat count alone; beats outside FILL are ignored.
- Reset values: FSM→IDLE, line_valid=0, pending=0, present=0, cnt=0. All outputs 0; data outputs zeroed.

## Timing
- icu_ifu_ack_ic1 is combinational from req/addr/state.
- ic2 latency:
  - 1 cycle after ack for a present beat.
  - 1 cycle after the beat's biu_icu_data_valid edge otherwise.
  - icu_ifu_data_valid_ic2 is a single-cycle pulse per accepted request.
- A same-cycle arrival of the pending beat and a new request is legal. The beat is forwarded next cycle, and the new request is not acked that cycle (pending still 1).
- Earliest new miss: the cycle after DONE (back in IDLE).
- lfb_wr_valid is asserted the cycle after the final beat, with lfb_wr_data containing all beats, including the final one.
- Reset asserted mid-fill: next cycle is IDLE with the line invalid; no lfb_wr_valid and no ic2 data for the aborted request.

## Test plan
- Fill with WRAP=0, BEATS=4, DATA_W=64:
  - Stimulus: req addr[31:3]=0x2021; after ack, beats 0xbbbb…, 0xcccc…, 0xdddd…, 0xeeee… (last on 4th).
  - Response: icu_biu_addr=0x00010100.
  - Response: ic2 valid with 0xcccccccccccccccc one cycle after the 2nd beat.
  - Response: lfb_wr_valid with addr 0x10100 and data {eeee,dddd,cccc,bbbb} one cycle after the 4th beat.
- Critical-first with WRAP=1:
  - Stimulus: same request.
  - Response: icu_biu_addr=0x00010108; first beat 0xcccc… lands in beat 1; ic2 returns it 1 cycle later.
  - Response: the 4th beat 0xbbbb… lands in beat 0; lfb_err=0.
- Hit-under-fill:
  - Stimulus: after the critical beat returns, req 0x2023 before the 4th beat.
  - Response: acked immediately; ic2 returns 0xeeee… one cycle after that beat arrives; no second icu_biu_req.
- Miss stall, then LFB hit:
  - Stimulus: req 0x2100 issued during the fill.
  - Response: ack=0 until after DONE; then ack and a new icu_biu_req with addr 0x10800.
  - Stimulus: separately, req 0x2020 after the fill completes.
  - Response: ack, and 0xbbbb… on ic2 next cycle with no BIU traffic.
- Reset mid-fill:
  - Stimulus: reset after the 2nd beat, then replay the remaining beats.
  - Response: all outputs 0; no lfb_wr_valid; replayed beats set lfb_err only after reset deasserts.
- Protocol error:
  - Stimulus: last asserted on the 3rd beat.
  - Response: lfb_err=1 and held; fill still completes after the 4th beat with lfb_wr_valid=1.
